uart_tx_frame_gen: RTL

- UART transmitter; counterpart of the UART Rx path, running on the same oversampled clock.
- Accepts a parallel byte with a valid strobe.
- Serialises it LSB-first as start, 8 data bits, optional parity and stop.
- Each bit is held for exactly Prescale clock cycles, so Tx and Rx share one clock and one Prescale setting.

---
 rtl/uart_tx_frame_gen_pkg.sv | 18 +
 rtl/uart_tx_bit_timer.sv | 53 +++++
 rtl/uart_tx_frame_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_gen_pkg.sv
// rtl/uart_tx_frame_gen_pkg.sv - shared UART Tx constants, state encodings and parity selectors
package uart_tx_frame_gen_pkg;

    // Wide enough to hold the value DATA_WIDTH (8) that the bit counter reaches after the last data bit.
    localparam int BIT_COUNTER_WIDTH = 4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// rtl/uart_tx_bit_timer.sv - per-bit edge counter and data bit counter for the UART transmitter
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_en            frame in progress; edge counter held at 0 while low
//   i_bit_en        data phase; bit counter held at 0 while low
//   i_prescale      latched clocks per bit
//   o_term          last clock of the current bit
//   o_bit_cnt       index of the data bit being sent
module uart_tx_bit_timer
    import uart_tx_frame_gen_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic                         i_bit_en,
    input  logic [PRESCALE_WIDTH-1:0]    i_prescale,
    output logic                         o_term,
    output logic [BIT_COUNTER_WIDTH-1:0] o_bit_cnt
);

    logic [PRESCALE_WIDTH-1:0]    r_edge_cnt;
    logic [BIT_COUNTER_WIDTH-1:0] r_bit_cnt;
    logic [PRESCALE_WIDTH-1:0]    w_last;

    assign w_last    = i_prescale - PRESCALE_WIDTH'(1);
    assign o_term    = i_en && (r_edge_cnt == w_last);
    assign o_bit_cnt = r_bit_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_edge_cnt <= '0;
        end else if (!i_en || o_term) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + PRESCALE_WIDTH'(1);
        end
    end

    // Increments past the last data bit, then clears once the FSM leaves the data phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= '0;
        end else if (!i_bit_en) begin
            r_bit_cnt <= '0;
        end else if (o_term) begin
            r_bit_cnt <= r_bit_cnt + BIT_COUNTER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// rtl/uart_tx_frame_gen.sv - UART transmitter: start, LSB-first data, optional parity, stop
//
// Ports:
//   CLK         oversampling clock, rising edge
//   RST         asynchronous active-low reset
//   P_DATA      byte to transmit
//   Data_Valid  P_DATA valid, sampled only while idle
//   PAR_EN      1 = append parity bit
//   PAR_TYP     0 = even, 1 = odd parity
//   Prescale    clocks per bit (2..31)
//   TX_OUT      serial line, idle high (registered)
//   Busy        frame in progress (registered)
module uart_tx_frame_gen
    import uart_tx_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    tx_state_t                    r_state;
    tx_state_t                    w_state_next;
    logic                         r_tx;
    logic                         r_busy;
    logic                         w_tx_next;
    logic                         w_busy_next;
    logic                         w_accept;
    logic                         w_shift;

    logic [DATA_WIDTH-1:0]        r_shift;
    logic                         r_parity;
    logic                         r_par_en;
    logic [PRESCALE_WIDTH-1:0]    r_prescale;

    logic                         w_term;
    logic [BIT_COUNTER_WIDTH-1:0] w_bit_cnt;
    logic                         w_last_data_bit;

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_bit_timer (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_en       (r_state != TX_IDLE),
        .i_bit_en   (r_state == TX_DATA),
        .i_prescale (r_prescale),
        .o_term     (w_term),
        .o_bit_cnt  (w_bit_cnt)
    );

    assign w_last_data_bit = (w_bit_cnt == BIT_COUNTER_WIDTH'(DATA_WIDTH - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= TX_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
        end
    end

    // Frame settings are frozen at acceptance; the shift register presents the next data bit at [0].
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_par_en   <= 1'b0;
            r_prescale <= '0;
        end else if (w_accept) begin
            r_shift    <= P_DATA;
            r_parity   <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
            r_par_en   <= PAR_EN;
            r_prescale <= Prescale;
        end else if (w_shift) begin
            r_shift    <= r_shift >> 1;
        end
    end

    // Next-state logic produces the value TX_OUT must carry during the following bit,
    // so the line changes on the same edge as the state.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_busy_next  = r_busy;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        unique case (r_state)
            TX_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
                if (Data_Valid) begin
                    w_accept     = 1'b1;
                    w_state_next = TX_START;
                    w_tx_next    = 1'b0;
                    w_busy_next  = 1'b1;
                end
            end
            TX_START: begin
                if (w_term) begin
                    w_state_next = TX_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            TX_DATA: begin
                if (w_term) begin
                    w_shift = 1'b1;
                    if (w_last_data_bit) begin
                        if (r_par_en) begin
                            w_state_next = TX_PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = TX_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_tx_next = r_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (w_term) begin
                    w_state_next = TX_STOP;
                    w_tx_next    = 1'b1;
                end
            end
            TX_STOP: begin
                if (w_term) begin
                    w_state_next = TX_IDLE;
                    w_tx_next    = 1'b1;
                    w_busy_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = TX_IDLE;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

endmodule
